// File: rtl/mmio_intr_ctrl_if.sv
// IOBUS slave port bundle for the interrupt controller: address, write data, write strobe, read data.
// Latency: none; plain wires.
// Backpressure: none; the IOBUS always completes in one cycle.
//
// Signals:
//   IOBUS_ADDR  CPU bus address
//   IOBUS_OUT   CPU write data
//   IOBUS_WR    CPU write strobe, sampled on rising CLK
//   RD_DATA     combinational read data back to the CPU, 0 on an address miss
interface mmio_intr_ctrl_if;
   logic [31:0] IOBUS_ADDR;
   logic [31:0] IOBUS_OUT;
   logic        IOBUS_WR;
   logic [31:0] RD_DATA;

   modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR, input  RD_DATA);
   modport slave  (input  IOBUS_ADDR, input  IOBUS_OUT, input  IOBUS_WR, output RD_DATA);
endinterface

// File: rtl/mmio_intr_ctrl.sv
// Edge-capturing, maskable, fixed-priority interrupt controller with a periodic re-fire pulse to the CPU.
// Latency: SRC rise to INTR pulse is 2 cycles; register reads are combinational.
// Backpressure: none; the bus never stalls and INTR is a one-cycle pulse with no acknowledge.
//
// Ports:
//   CLK, RST_N  system clock, asynchronous active-low reset
//   bus         IOBUS slave (PENDING +0 W1C, ENABLE +4 RW, CAUSE +8 RO)
//   SRC         level interrupt sources, synchronous to CLK
//   INTR        registered single-cycle interrupt pulse
module mmio_intr_ctrl #(
   parameter int          N_SRC      = 4,
   parameter logic [31:0] BASE_AD    = 32'h11000060,
   parameter int          REFIRE_CYC = 1024
) (
   input  logic             CLK,
   input  logic             RST_N,
   mmio_intr_ctrl_if.slave  bus,
   input  logic [N_SRC-1:0] SRC,
   output logic             INTR
);

   typedef enum logic [1:0] {ST_IDLE, ST_FIRE, ST_WAIT} state_t;

   localparam logic [31:0] AD_PEND  = BASE_AD;
   localparam logic [31:0] AD_EN    = BASE_AD + 32'd4;
   localparam logic [31:0] AD_CAUSE = BASE_AD + 32'd8;
   localparam logic [15:0] CNT_LAST = 16'(REFIRE_CYC - 1);

   state_t           state;
   logic [15:0]      cnt;
   logic [N_SRC-1:0] src_q;
   logic [N_SRC-1:0] pending;
   logic [N_SRC-1:0] enable;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] act;
   logic [N_SRC-1:0] wr_dat;
   logic [N_SRC-1:0] clr_mask;
   logic             wr_pend;
   logic             wr_en;
   logic [3:0]       act_idx;
   logic             cause_vld;
   logic [3:0]       cause_idx;

   assign wr_dat   = bus.IOBUS_OUT[N_SRC-1:0];
   assign wr_pend  = bus.IOBUS_WR && (bus.IOBUS_ADDR == AD_PEND);
   assign wr_en    = bus.IOBUS_WR && (bus.IOBUS_ADDR == AD_EN);
   assign clr_mask = wr_pend ? wr_dat : '0;
   assign rise     = SRC & ~src_q;
   assign act      = pending & enable;

   // Lowest index wins: scan downward so the last hit is the lowest set bit.
   always_comb begin
      act_idx = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (act[i]) act_idx = 4'(i);
      end
   end

   always_comb begin
      bus.RD_DATA = '0;
      if (bus.IOBUS_ADDR == AD_PEND)       bus.RD_DATA = 32'(pending);
      else if (bus.IOBUS_ADDR == AD_EN)    bus.RD_DATA = 32'(enable);
      else if (bus.IOBUS_ADDR == AD_CAUSE) bus.RD_DATA = {cause_vld, 27'b0, cause_idx};
   end

   // A rise in the same cycle as a W1C of that bit keeps the bit set.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         src_q   <= '0;
         pending <= '0;
         enable  <= '0;
      end else begin
         src_q   <= SRC;
         pending <= (pending & ~clr_mask) | rise;
         if (wr_en) enable <= wr_dat;
      end
   end

   // FSM decisions use the registered act, so bus writes take effect one edge later.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         INTR      <= 1'b0;
         cause_vld <= 1'b0;
         cause_idx <= '0;
      end else begin
         INTR <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (act != '0) begin
                  state     <= ST_FIRE;
                  INTR      <= 1'b1;
                  cause_vld <= 1'b1;
                  cause_idx <= act_idx;
               end
            end
            ST_FIRE: begin
               state <= ST_WAIT;
               cnt   <= '0;
            end
            ST_WAIT: begin
               // Quiescing takes priority over re-firing.
               if (act == '0) begin
                  state     <= ST_IDLE;
                  cause_vld <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state     <= ST_FIRE;
                  INTR      <= 1'b1;
                  cause_vld <= 1'b1;
                  cause_idx <= act_idx;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_intr_ctrl.sv
// Randomized and directed bench for mmio_intr_ctrl with a queue-based scoreboard against an event-time model.
// Latency: inputs driven 1 ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: none on the DUT; the bench never waits on a DUT event.
module tb_mmio_intr_ctrl;
   localparam int          R    = 8;
   localparam logic [31:0] BASE = 32'h11000060;

   logic       CLK    = 1'b0;
   logic       RST_N  = 1'b0;
   logic [3:0] SRC    = '0;
   logic       INTR;
   logic       rd_req = 1'b0;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   mmio_intr_ctrl_if bus ();

   mmio_intr_ctrl #(.N_SRC(4), .BASE_AD(BASE), .REFIRE_CYC(R)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus),
      .SRC   (SRC),
      .INTR  (INTR)
   );

   initial forever #5 CLK = ~CLK;

   // Reference model: registers as plain values, interrupt timing as arithmetic on the last fire cycle.
   logic [3:0]  m_pend, m_en, m_src_prev;
   logic [31:0] m_cause;
   bit          m_busy;
   int          m_last;
   int          intr_q[$];
   logic [31:0] rd_q[$];
   int          intr_log[$];

   function automatic int low_idx(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (a == BASE)          return {28'b0, m_pend};
      if (a == BASE + 32'd4)  return {28'b0, m_en};
      if (a == BASE + 32'd8)  return m_cause;
      return 32'h0;
   endfunction

   initial begin
      logic [3:0] act, clr;
      forever begin
         @(posedge CLK or negedge RST_N);
         if (!RST_N) begin
            m_pend = '0; m_en = '0; m_src_prev = '0; m_cause = '0;
            m_busy = 0; m_last = 0;
            intr_q.delete();
         end else begin
            cyc++;
            act = m_pend & m_en;
            if (m_busy) begin
               // The cycle right after a pulse never reacts to act.
               if (cyc != m_last + 1) begin
                  if (act == 4'b0) begin
                     m_busy = 0;
                     m_cause[31] = 1'b0;
                  end else if (cyc == m_last + R + 1) begin
                     m_last = cyc; m_cause = {1'b1, 27'b0, 4'(low_idx(act))};
                     intr_q.push_back(cyc);
                  end
               end
            end else if (act != 4'b0) begin
               m_busy = 1; m_last = cyc; m_cause = {1'b1, 27'b0, 4'(low_idx(act))};
               intr_q.push_back(cyc);
            end
            clr = (bus.IOBUS_WR && bus.IOBUS_ADDR == BASE) ? bus.IOBUS_OUT[3:0] : 4'b0;
            m_pend = (m_pend & ~clr) | (SRC & ~m_src_prev);
            if (bus.IOBUS_WR && bus.IOBUS_ADDR == BASE + 32'd4) m_en = bus.IOBUS_OUT[3:0];
            m_src_prev = SRC;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   // Monitor: pops expected pulses and reads as the DUT presents them.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge CLK);
         if (RST_N) begin
            while (intr_q.size() > 0 && intr_q[0] < cyc) begin
               checks++; failures++;
               $display("FAIL intr_missing got=none exp_cycle=%0d now=%0d", intr_q[0], cyc);
               void'(intr_q.pop_front());
            end
            if (INTR) begin
               intr_log.push_back(cyc);
               checks++;
               if (intr_q.size() > 0 && intr_q[0] == cyc) void'(intr_q.pop_front());
               else begin
                  failures++;
                  $display("FAIL intr_unexpected got=1 at cycle %0d exp=0", cyc);
               end
            end
            if (rd_req) begin
               if (rd_q.size() > 0) begin
                  e = rd_q.pop_front();
                  chk($sformatf("rd_%h", bus.IOBUS_ADDR), bus.RD_DATA, e);
               end else begin
                  checks++; failures++;
                  $display("FAIL rd_no_expect got=%h exp=none", bus.RD_DATA);
               end
            end
         end
      end
   end

   task automatic drive(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit rd);
      @(posedge CLK); #1;
      bus.IOBUS_WR   = wr;
      bus.IOBUS_ADDR = a;
      bus.IOBUS_OUT  = d;
      rd_req         = rd;
      if (rd) rd_q.push_back(model_read(a));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 32'h0, 32'h0, 0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      drive(1, a, d, 0);
   endtask

   // Read with both the model expectation and an independent constant.
   task automatic rdc(input logic [31:0] a, input logic [31:0] exp, input string nm);
      drive(0, a, 32'h0, 1);
      @(negedge CLK); #1;
      chk(nm, bus.RD_DATA, exp);
   endtask

   initial begin
      int n0;
      logic [3:0] tgl;
      logic [31:0] a;
      int r;
      bus.IOBUS_WR = 0; bus.IOBUS_ADDR = '0; bus.IOBUS_OUT = '0;
      repeat (3) @(posedge CLK);
      #1 RST_N = 1'b1;

      rdc(BASE,          32'h0, "rst_pending");
      rdc(BASE + 32'd4,  32'h0, "rst_enable");
      rdc(BASE + 32'd8,  32'h0, "rst_cause");
      chk("rst_intr", 32'(INTR), 32'h0);

      // Basic fire
      wr(BASE + 32'd4, 32'h5); SRC = 4'b0100;
      idle(1); SRC = 4'b0000;
      rdc(BASE, 32'h4, "basic_pending");
      rdc(BASE + 32'd8, 32'h80000002, "basic_cause");
      wr(BASE, 32'h4);
      idle(12);
      rdc(BASE + 32'd8, 32'h00000002, "basic_cause_cleared");

      // Priority
      wr(BASE + 32'd4, 32'hF); SRC = 4'b1010;
      idle(1); SRC = 4'b0000;
      idle(3);
      rdc(BASE + 32'd8, 32'h80000001, "prio_cause_first");
      wr(BASE, 32'h2);
      rdc(BASE, 32'h8, "prio_pending_after_w1c");
      idle(10);
      rdc(BASE + 32'd8, 32'h80000003, "prio_cause_refire");
      wr(BASE, 32'h8);
      idle(4);

      // Re-fire period
      wr(BASE + 32'd4, 32'h1); SRC = 4'b0001;
      idle(1); SRC = 4'b0000;
      idle(30);
      chk("refire_period", 32'(intr_log[intr_log.size()-1] - intr_log[intr_log.size()-2]), 32'd9);
      wr(BASE, 32'h1);
      idle(12);
      rdc(BASE + 32'd8, 32'h00000000, "refire_cause_cleared");

      // Masking
      n0 = intr_log.size();
      wr(BASE + 32'd4, 32'h0); SRC = 4'b0001;
      idle(1); SRC = 4'b0000;
      rdc(BASE, 32'h1, "mask_pending");
      idle(5);
      chk("mask_no_intr", 32'(intr_log.size() - n0), 32'd0);
      wr(BASE + 32'd4, 32'h1);
      idle(4);
      chk("mask_intr_after_enable", 32'(intr_log.size() - n0), 32'd1);
      wr(BASE, 32'h1);
      idle(4);

      // Set/clear collision and write width
      wr(BASE + 32'd4, 32'h0); SRC = 4'b0000;
      idle(2);
      wr(BASE, 32'h1); SRC = 4'b0001;
      idle(1); SRC = 4'b0000;
      rdc(BASE, 32'h1, "collision_pending");
      wr(BASE + 32'd4, 32'hFFFFFFFF);
      rdc(BASE + 32'd4, 32'h0000000F, "enable_width");
      wr(BASE, 32'hFFFFFFFF);
      wr(BASE + 32'd4, 32'h0);
      idle(4);

      // Reset mid-WAIT
      wr(BASE + 32'd4, 32'h1); SRC = 4'b0001;
      idle(5);
      @(posedge CLK); #3;
      RST_N = 1'b0;
      #1 chk("rst_async_intr", 32'(INTR), 32'h0);
      bus.IOBUS_ADDR = BASE;         #1 chk("rst_async_pending", bus.RD_DATA, 32'h0);
      bus.IOBUS_ADDR = BASE + 32'd4; #1 chk("rst_async_enable",  bus.RD_DATA, 32'h0);
      bus.IOBUS_ADDR = BASE + 32'd8; #1 chk("rst_async_cause",   bus.RD_DATA, 32'h0);
      @(posedge CLK); #1 RST_N = 1'b1;
      n0 = intr_log.size();
      wr(BASE + 32'd4, 32'h1);
      idle(4);
      chk("rst_new_intr", 32'(intr_log.size() > n0), 32'h1);
      rdc(BASE, 32'h1, "rst_rise_pending");
      SRC = 4'b0000;
      wr(BASE, 32'h1);
      wr(BASE + 32'd4, 32'h0);
      idle(4);

      // Randomized traffic, checked entirely by the model
      for (int k = 0; k < 1500; k++) begin
         r = $urandom_range(0, 9);
         case ($urandom_range(0, 5))
            0: a = BASE;
            1: a = BASE + 32'd4;
            2: a = BASE + 32'd8;
            3: a = BASE + 32'hC;
            4: a = BASE + 32'h10;
            default: a = $urandom;
         endcase
         drive(r < 2, a, $urandom, r >= 5);
         tgl = 4'($urandom) & 4'($urandom) & 4'($urandom);
         SRC = SRC ^ tgl;
      end
      idle(30);
      @(negedge CLK); #1;
      chk("intr_queue_drained", 32'(intr_q.size()), 32'h0);
      chk("rd_queue_drained", 32'(rd_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
